// File: rtl/alu_rr_arbiter.sv
// Two-client round-robin front end for a shared combinational ALU: latches the
// winner's operands, captures the ALU result one cycle later, pulses done.
module alu_rr_arbiter #(
  parameter int DW = 2,
  parameter int SW = 2,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [SW-1:0] sel0,
  output logic          gnt0,
  output logic          done0,
  output logic [RW-1:0] y0,
  input  logic          req1,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  input  logic [SW-1:0] sel1,
  output logic          gnt1,
  output logic          done1,
  output logic [RW-1:0] y1,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [RW-1:0] alu_y,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // requester currently holding the ALU
  logic          last_q, last_d;    // requester served most recently
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SW-1:0] alu_sel_q, alu_sel_d;
  logic [RW-1:0] y0_q, y0_d, y1_q, y1_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Contention goes to whoever was not served last; a sole requester always wins.
          owner_d   = (req0 && req1) ? ~last_q : req1;
          alu_a_d   = owner_d ? a1   : a0;
          alu_b_d   = owner_d ? b1   : b0;
          alu_sel_d = owner_d ? sel1 : sel0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) y1_d = alu_y;
        else         y0_d = alu_y;
        state_d = DONE;
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign gnt0    = busy && !owner_q;
  assign gnt1    = busy &&  owner_q;
  assign done0   = (state_q == DONE) && !owner_q;
  assign done1   = (state_q == DONE) &&  owner_q;
  assign y0      = y0_q;
  assign y1      = y1_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a concatenating ALU stub (Y = {A, B}).
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] a0 = '0, b0 = '0, sel0 = '0, a1 = '0, b1 = '0, sel1 = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] y0, y1, alu_y;
  logic [1:0] alu_a, alu_b, alu_sel;

  int n_chk = 0;
  int n_fail = 0;

  alu_rr_arbiter #(.DW(2), .SW(2), .RW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sel0(sel0), .gnt0(gnt0), .done0(done0), .y0(y0),
    .req1(req1), .a1(a1), .b1(b1), .sel1(sel1), .gnt1(gnt1), .done1(done1), .y1(y1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .busy(busy)
  );

  assign alu_y = {alu_a, alu_b};

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       r0;
    logic [1:0] a0, b0, s0;
    logic       r1;
    logic [1:0] a1, b1, s1;
    logic       w;
    logic [3:0] y;
  } vec_t;

  vec_t       vt[7];
  logic [3:0] ey0, ey1;

  initial begin
    // Pointer starts favouring requester 0; winners below follow from that.
    vt[0] = '{1'b1, 2'b01, 2'b10, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'b0110};
    vt[1] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 2'b01, 2'b10, 1'b1, 4'b1101};
    vt[2] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b01, 1'b1, 4'b1000};
    vt[3] = '{1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 2'b01, 2'b01, 2'b11, 1'b0, 4'b0011};
    vt[4] = '{1'b1, 2'b10, 2'b10, 2'b01, 1'b1, 2'b11, 2'b10, 2'b10, 1'b1, 4'b1110};
    vt[5] = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'b1111};
    vt[6] = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 2'b10, 1'b1, 4'b0000};

    do_reset();
    check("rst_busy", 4'(busy), 4'd0);
    check("rst_gnt0", 4'(gnt0), 4'd0);
    check("rst_gnt1", 4'(gnt1), 4'd0);
    check("rst_done0", 4'(done0), 4'd0);
    check("rst_done1", 4'(done1), 4'd0);
    check("rst_y0", y0, 4'd0);
    check("rst_y1", y1, 4'd0);
    check("rst_alu_a", 4'(alu_a), 4'd0);
    check("rst_alu_sel", 4'(alu_sel), 4'd0);

    ey0 = 4'd0;
    ey1 = 4'd0;
    for (int i = 0; i < 7; i++) begin
      req0 = vt[i].r0; a0 = vt[i].a0; b0 = vt[i].b0; sel0 = vt[i].s0;
      req1 = vt[i].r1; a1 = vt[i].a1; b1 = vt[i].b1; sel1 = vt[i].s1;
      @(negedge clk);
      check("vec_exec_busy", 4'(busy), 4'd1);
      check("vec_exec_gnt0", 4'(gnt0), 4'(!vt[i].w));
      check("vec_exec_gnt1", 4'(gnt1), 4'(vt[i].w));
      check("vec_exec_alu_a", 4'(alu_a), 4'(vt[i].w ? vt[i].a1 : vt[i].a0));
      check("vec_exec_alu_sel", 4'(alu_sel), 4'(vt[i].w ? vt[i].s1 : vt[i].s0));
      if (vt[i].w) ey1 = vt[i].y;
      else         ey0 = vt[i].y;
      @(negedge clk);
      check("vec_done0", 4'(done0), 4'(!vt[i].w));
      check("vec_done1", 4'(done1), 4'(vt[i].w));
      check("vec_y0", y0, ey0);
      check("vec_y1", y1, ey1);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check("vec_idle_busy", 4'(busy), 4'd0);
      check("vec_idle_done", 4'({done0, done1}), 4'd0);
    end

    // Both requesters held from reset: strict 0,1,0,1 alternation every 3 cycles.
    do_reset();
    a0 = 2'b01; b0 = 2'b00; sel0 = 2'b10;
    a1 = 2'b11; b1 = 2'b11; sel1 = 2'b01;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("alt_done0", 4'(done0), 4'((k % 6) == 2));
      check("alt_done1", 4'(done1), 4'((k % 6) == 5));
      check("alt_gnt0", 4'(gnt0), 4'(((k % 6) == 1) || ((k % 6) == 2)));
      check("alt_gnt1", 4'(gnt1), 4'(((k % 6) == 4) || ((k % 6) == 5)));
      if ((k % 6) == 2) check("alt_y0", y0, 4'b0100);
      if ((k % 6) == 5) check("alt_y1", y1, 4'b1111);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Operand change after latching must not affect the result.
    do_reset();
    req0 = 1'b1; a0 = 2'b01; b0 = 2'b10; sel0 = 2'b11;
    @(negedge clk);
    check("late_gnt0", 4'(gnt0), 4'd1);
    a0 = 2'b11;
    @(negedge clk);
    check("late_alu_a", 4'(alu_a), 4'b0001);
    check("late_done0", 4'(done0), 4'd1);
    check("late_y0", y0, 4'b0110);
    req0 = 1'b0;
    @(negedge clk);

    // Reset during EXEC aborts the op with no done and no result.
    do_reset();
    req1 = 1'b1; a1 = 2'b10; b1 = 2'b01; sel1 = 2'b01;
    @(negedge clk);
    check("abort_gnt1_exec", 4'(gnt1), 4'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 4'(busy), 4'd0);
    check("abort_gnt1", 4'(gnt1), 4'd0);
    check("abort_done1", 4'(done1), 4'd0);
    check("abort_y1", y1, 4'd0);
    rst = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("abort_done1_after", 4'(done1), 4'd0);
    check("abort_y1_after", y1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && done0 && done1) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_exclusive: done0=%b done1=%b expected not both high", done0, done1);
    end
  end

endmodule
